// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared types and width helpers for the PLL dynamic-config sequencer
package pll_ctrl_pkg;
  localparam int SEL_W = 6;
  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, DRAIN, FAIL} state_e;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta_q} <= 2'b00;
    else {q, meta_q} <= {meta_q, d};
endmodule

// File: rtl/pll_dyn_cfg_ctrl.sv
// pll_dyn_cfg_ctrl: rPLL reset/divider sequencer with lock qualification, retry and runtime reconfig
module pll_dyn_cfg_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int DRAIN_CYCLES  = 4,
  parameter logic [SEL_W-1:0] DEF_IDSEL  = '0,
  parameter logic [SEL_W-1:0] DEF_FBDSEL = '0,
  parameter logic [SEL_W-1:0] DEF_ODSEL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SEL_W-1:0] cfg_idsel,
  input  logic [SEL_W-1:0] cfg_fbdsel,
  input  logic [SEL_W-1:0] cfg_odsel,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic [SEL_W-1:0] pll_idsel,
  output logic [SEL_W-1:0] pll_fbdsel,
  output logic [SEL_W-1:0] pll_odsel,
  output logic             sys_rst_n,
  output logic             locked,
  output logic             busy,
  output logic             fail,
  output logic [7:0]       lock_loss_cnt
);
  localparam int RW_A = cnt_w(RST_CYCLES) > cnt_w(STABLE_CYCLES) ? cnt_w(RST_CYCLES) : cnt_w(STABLE_CYCLES);
  localparam int CW   = RW_A > cnt_w(DRAIN_CYCLES) ? RW_A : cnt_w(DRAIN_CYCLES);
  localparam int TW   = cnt_w(LOCK_TIMEOUT);
  localparam int RW   = cnt_w(MAX_RETRIES + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [RW-1:0]    retry_q, retry_d, retry_inc;
  logic [SEL_W-1:0] idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
  logic [7:0]       lock_loss_q, lock_loss_d;
  logic             pll_reset_q, pll_reset_d, sys_rst_n_q, sys_rst_n_d, locked_q, locked_d;
  logic             busy_q, busy_d, fail_q, fail_d, cfg_ready_q, cfg_ready_d;
  logic             lock_s, tmo_hit, stable_done, loss, xfer;

  sync_2ff u_lock_sync (.clk(clk), .rst_n(rst_n), .d(pll_lock), .q(lock_s));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    // timeout keeps running across WAIT_LOCK<->STABLE so a flapping lock still expires
    tmo_d       = (state_q == WAIT_LOCK || state_q == STABLE) ? tmo_q + 1'b1 : '0;
    retry_d     = retry_q;
    retry_inc   = retry_q + 1'b1;
    tmo_hit     = tmo_q == TW'(LOCK_TIMEOUT - 1);
    stable_done = lock_s && cnt_q == CW'(STABLE_CYCLES - 1);
    loss        = state_q == RUN && !lock_s;
    xfer        = cfg_valid && cfg_ready_q && !loss;
    lock_loss_d = (loss && lock_loss_q != 8'hff) ? lock_loss_q + 8'd1 : lock_loss_q;
    {idsel_d, fbdsel_d, odsel_d} = xfer ? {cfg_idsel, cfg_fbdsel, cfg_odsel} : {idsel_q, fbdsel_q, odsel_q};
    case (state_q)
      PLL_RST: if (cnt_q == CW'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
      WAIT_LOCK, STABLE:
        if (state_q == STABLE && stable_done) begin
          state_d = RUN;
          retry_d = '0;
        end else if (tmo_hit) begin
          retry_d = retry_inc;
          state_d = retry_inc >= RW'(MAX_RETRIES) ? FAIL : PLL_RST;
        end else state_d = lock_s ? STABLE : WAIT_LOCK;
      RUN:   if (loss) state_d = PLL_RST;
      DRAIN: if (cnt_q == CW'(DRAIN_CYCLES - 1)) state_d = PLL_RST;
      default: ;
    endcase
    if (xfer) begin
      state_d = DRAIN;
      retry_d = '0;
    end
    // the lock_s high that moved us into STABLE already counts as the first stable cycle
    if (state_d != state_q) cnt_d = state_d == STABLE ? CW'(1) : '0;
    pll_reset_d = state_d == PLL_RST || state_d == FAIL;
    sys_rst_n_d = state_d == RUN;
    locked_d    = state_d == RUN;
    busy_d      = !(state_d == RUN || state_d == FAIL);
    fail_d      = state_d == FAIL;
    cfg_ready_d = state_d == RUN || state_d == FAIL;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      idsel_q     <= DEF_IDSEL;
      fbdsel_q    <= DEF_FBDSEL;
      odsel_q     <= DEF_ODSEL;
      lock_loss_q <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      busy_q      <= 1'b1;
      fail_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      idsel_q     <= idsel_d;
      fbdsel_q    <= fbdsel_d;
      odsel_q     <= odsel_d;
      lock_loss_q <= lock_loss_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      locked_q    <= locked_d;
      busy_q      <= busy_d;
      fail_q      <= fail_d;
      cfg_ready_q <= cfg_ready_d;
    end

  assign pll_reset     = pll_reset_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign locked        = locked_q;
  assign busy          = busy_q;
  assign fail          = fail_q;
  assign cfg_ready     = cfg_ready_q;
  assign lock_loss_cnt = lock_loss_q;
  assign pll_idsel     = idsel_q;
  assign pll_fbdsel    = fbdsel_q;
  assign pll_odsel     = odsel_q;
endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// tb_pll_dyn_cfg_ctrl: scenario bench for the PLL sequencer; expectations queued at stimulus, popped at observation
module tb_pll_dyn_cfg_ctrl;
  localparam logic [5:0] D_ID = 6'd5, D_FB = 6'd7, D_OD = 6'd9;
  localparam int DEF_SELS = (5 << 12) | (7 << 6) | 9;
  localparam int ST_RST = 6'b100100, ST_RUN = 6'b011001, ST_BUSY = 6'b000100, ST_FAIL = 6'b100011;

  logic clk = 0, rst_n = 0, cfg_valid = 0, pll_lock = 0;
  logic [5:0] cfg_idsel = 0, cfg_fbdsel = 0, cfg_odsel = 0;
  logic cfg_ready, pll_reset, sys_rst_n, locked, busy, fail;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic [7:0] lock_loss_cnt;
  logic [5:0] st;
  logic [17:0] sels;
  int errors = 0, checks = 0;
  int exp_q[$];

  assign st   = {pll_reset, sys_rst_n, locked, busy, fail, cfg_ready};
  assign sels = {pll_idsel, pll_fbdsel, pll_odsel};

  pll_dyn_cfg_ctrl #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(100), .STABLE_CYCLES(8), .MAX_RETRIES(2), .DRAIN_CYCLES(4),
    .DEF_IDSEL(D_ID), .DEF_FBDSEL(D_FB), .DEF_ODSEL(D_OD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
    .pll_lock(pll_lock), .pll_reset(pll_reset), .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel),
    .pll_odsel(pll_odsel), .sys_rst_n(sys_rst_n), .locked(locked), .busy(busy), .fail(fail),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // negedges until the chosen output (0=pll_reset, 1=sys_rst_n) equals val; limit+1 on expiry
  task automatic count_until(input int sel, input logic val, input int limit, output int n);
    n = 0;
    do begin @(negedge clk); n++; end
    while ((sel == 0 ? pll_reset : sys_rst_n) !== val && n <= limit);
  endtask

  task automatic apply_reset();
    rst_n = 0; cfg_valid = 0; pll_lock = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    int e;
    rst_n = 0;
    repeat (3) @(negedge clk);
    exp_q.push_back(ST_RST); exp_q.push_back(DEF_SELS); exp_q.push_back(0);
    e = exp_q.pop_front(); checks++;
    if (int'(st) !== e) begin errors++; $display("FAIL rst_flags: got %b expected %b", st, 6'(e)); end
    e = exp_q.pop_front(); checks++;
    if (int'(sels) !== e) begin errors++; $display("FAIL rst_sels: got %h expected %h", sels, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(lock_loss_cnt) !== e) begin errors++; $display("FAIL rst_loss_cnt: got %0d expected %0d", lock_loss_cnt, e); end
  endtask

  task automatic test_power_up();
    int n, e;
    rst_n = 1;
    exp_q.push_back(4); count_until(0, 0, 20, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin errors++; $display("FAIL pu_rst_pulse: got %0d expected %0d", n, e); end
    exp_q.push_back(ST_BUSY);
    e = exp_q.pop_front(); checks++;
    if (int'(st) !== e) begin errors++; $display("FAIL pu_wait_flags: got %b expected %b", st, 6'(e)); end
    repeat (16) @(negedge clk);
    pll_lock = 1;
    exp_q.push_back(10); count_until(1, 1, 50, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin errors++; $display("FAIL pu_lock_latency: got %0d expected %0d", n, e); end
    exp_q.push_back(ST_RUN);
    e = exp_q.pop_front(); checks++;
    if (int'(st) !== e) begin errors++; $display("FAIL pu_run_flags: got %b expected %b", st, 6'(e)); end
  endtask

  task automatic test_reconfig();
    int n, e;
    repeat (3) @(negedge clk);
    cfg_valid = 1; cfg_idsel = 3; cfg_fbdsel = 10; cfg_odsel = 8;
    exp_q.push_back(int'({6'd3, 6'd10, 6'd8})); exp_q.push_back(ST_BUSY);
    @(negedge clk);
    cfg_valid = 0;
    e = exp_q.pop_front(); checks++;
    if (int'(sels) !== e) begin errors++; $display("FAIL rc_sels: got %h expected %h", sels, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(st) !== e) begin errors++; $display("FAIL rc_drain_flags: got %b expected %b", st, 6'(e)); end
    exp_q.push_back(4); count_until(0, 1, 20, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin errors++; $display("FAIL rc_drain_len: got %0d expected %0d", n, e); end
    exp_q.push_back(12); count_until(1, 1, 50, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin errors++; $display("FAIL rc_relock: got %0d expected %0d", n, e); end
    exp_q.push_back(int'({6'd3, 6'd10, 6'd8}));
    e = exp_q.pop_front(); checks++;
    if (int'(sels) !== e) begin errors++; $display("FAIL rc_sels_hold: got %h expected %h", sels, e); end
  endtask

  task automatic test_lock_loss();
    int n, e;
    for (int i = 0; i < 3; i++) begin
      repeat (3) @(negedge clk);
      pll_lock = 0;
      exp_q.push_back(3); exp_q.push_back(ST_RST); exp_q.push_back(i + 1); exp_q.push_back(12);
      @(negedge clk);
      pll_lock = 1;
      count_until(1, 0, 10, n);
      e = exp_q.pop_front(); checks++;
      if (n + 1 !== e) begin errors++; $display("FAIL ll_latency[%0d]: got %0d expected %0d", i, n + 1, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(st) !== e) begin errors++; $display("FAIL ll_flags[%0d]: got %b expected %b", i, st, 6'(e)); end
      e = exp_q.pop_front(); checks++;
      if (int'(lock_loss_cnt) !== e) begin errors++; $display("FAIL ll_count[%0d]: got %0d expected %0d", i, lock_loss_cnt, e); end
      count_until(1, 1, 50, n);
      e = exp_q.pop_front(); checks++;
      if (n !== e) begin errors++; $display("FAIL ll_relock[%0d]: got %0d expected %0d", i, n, e); end
    end
  endtask

  task automatic test_simultaneous();
    int n, e;
    repeat (3) @(negedge clk);
    pll_lock = 0;
    exp_q.push_back(int'({6'd3, 6'd10, 6'd8})); exp_q.push_back(ST_RST); exp_q.push_back(4); exp_q.push_back(12);
    @(negedge clk);
    pll_lock = 1;
    @(negedge clk);
    cfg_valid = 1; cfg_idsel = 1; cfg_fbdsel = 2; cfg_odsel = 3;
    @(negedge clk);
    cfg_valid = 0;
    e = exp_q.pop_front(); checks++;
    if (int'(sels) !== e) begin errors++; $display("FAIL sim_sels: got %h expected %h", sels, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(st) !== e) begin errors++; $display("FAIL sim_flags: got %b expected %b", st, 6'(e)); end
    e = exp_q.pop_front(); checks++;
    if (int'(lock_loss_cnt) !== e) begin errors++; $display("FAIL sim_loss_cnt: got %0d expected %0d", lock_loss_cnt, e); end
    count_until(1, 1, 50, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin errors++; $display("FAIL sim_relock: got %0d expected %0d", n, e); end
  endtask

  task automatic test_async_reset();
    int n, e;
    pll_lock = 0;
    count_until(1, 0, 10, n);
    exp_q.push_back(4); count_until(0, 0, 20, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin errors++; $display("FAIL ar_wait_entry: got %0d expected %0d", n, e); end
    exp_q.push_back(5);
    e = exp_q.pop_front(); checks++;
    if (int'(lock_loss_cnt) !== e) begin errors++; $display("FAIL ar_loss_before: got %0d expected %0d", lock_loss_cnt, e); end
    repeat (5) @(negedge clk);
    cfg_valid = 1; cfg_idsel = 1; cfg_fbdsel = 2; cfg_odsel = 3;
    exp_q.push_back(int'({6'd3, 6'd10, 6'd8})); exp_q.push_back(ST_RST); exp_q.push_back(DEF_SELS); exp_q.push_back(0);
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if (int'(sels) !== e) begin errors++; $display("FAIL ar_no_xfer: got %h expected %h", sels, e); end
    #1 rst_n = 0;
    #1;
    e = exp_q.pop_front(); checks++;
    if (int'(st) !== e) begin errors++; $display("FAIL ar_flags: got %b expected %b", st, 6'(e)); end
    e = exp_q.pop_front(); checks++;
    if (int'(sels) !== e) begin errors++; $display("FAIL ar_sels: got %h expected %h", sels, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(lock_loss_cnt) !== e) begin errors++; $display("FAIL ar_loss_cnt: got %0d expected %0d", lock_loss_cnt, e); end
    @(negedge clk);
    cfg_valid = 0;
  endtask

  task automatic test_flapping();
    int n, e;
    logic seen_run;
    apply_reset();
    exp_q.push_back(4); count_until(0, 0, 20, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin errors++; $display("FAIL fl_wait_entry: got %0d expected %0d", n, e); end
    seen_run = 0;
    exp_q.push_back(100); exp_q.push_back(0);
    fork
      for (int k = 0; k < 12; k++) begin
        pll_lock = (k % 2 == 0);
        repeat (5) @(negedge clk);
      end
      count_until(0, 1, 200, n);
      repeat (120) begin @(negedge clk); if (sys_rst_n) seen_run = 1; end
    join
    pll_lock = 0;
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin errors++; $display("FAIL fl_timeout: got %0d expected %0d", n, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(seen_run) !== e) begin errors++; $display("FAIL fl_no_run: got %0d expected %0d", seen_run, e); end
  endtask

  task automatic test_timeout_fail();
    int n, e;
    apply_reset();
    exp_q.push_back(4); exp_q.push_back(100); exp_q.push_back(4); exp_q.push_back(100);
    for (int i = 0; i < 4; i++) begin
      count_until(0, i[0] ? 1'b1 : 1'b0, 300, n);
      e = exp_q.pop_front(); checks++;
      if (n !== e) begin errors++; $display("FAIL to_phase[%0d]: got %0d expected %0d", i, n, e); end
    end
    exp_q.push_back(ST_FAIL); exp_q.push_back(ST_FAIL);
    e = exp_q.pop_front(); checks++;
    if (int'(st) !== e) begin errors++; $display("FAIL to_fail_flags: got %b expected %b", st, 6'(e)); end
    repeat (10) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (int'(st) !== e) begin errors++; $display("FAIL to_fail_hold: got %b expected %b", st, 6'(e)); end
  endtask

  task automatic test_fail_exit();
    int n, e;
    cfg_valid = 1; cfg_idsel = 12; cfg_fbdsel = 34; cfg_odsel = 56;
    exp_q.push_back(int'({6'd12, 6'd34, 6'd56})); exp_q.push_back(ST_BUSY);
    @(negedge clk);
    cfg_valid = 0;
    e = exp_q.pop_front(); checks++;
    if (int'(sels) !== e) begin errors++; $display("FAIL fx_sels: got %h expected %h", sels, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(st) !== e) begin errors++; $display("FAIL fx_drain_flags: got %b expected %b", st, 6'(e)); end
    exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(100); exp_q.push_back(4);
    for (int i = 0; i < 4; i++) begin
      count_until(0, i[0] ? 1'b0 : 1'b1, 300, n);
      e = exp_q.pop_front(); checks++;
      if (n !== e) begin errors++; $display("FAIL fx_phase[%0d]: got %0d expected %0d", i, n, e); end
    end
    pll_lock = 1;
    exp_q.push_back(10); count_until(1, 1, 50, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin errors++; $display("FAIL fx_relock: got %0d expected %0d", n, e); end
    exp_q.push_back(ST_RUN); exp_q.push_back(int'({6'd12, 6'd34, 6'd56}));
    e = exp_q.pop_front(); checks++;
    if (int'(st) !== e) begin errors++; $display("FAIL fx_run_flags: got %b expected %b", st, 6'(e)); end
    e = exp_q.pop_front(); checks++;
    if (int'(sels) !== e) begin errors++; $display("FAIL fx_sels_hold: got %h expected %h", sels, e); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_reconfig();
    test_lock_loss();
    test_simultaneous();
    test_async_reset();
    test_flapping();
    test_timeout_fail();
    test_fail_exit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pll_dyn_cfg_ctrl.md
Name: pll_dyn_cfg_ctrl

Overview:
Sequencer for the Gowin rPLL in dynamic-divider mode: owns PLL RESET and the IDSEL/FBDSEL/ODSEL buses. Runs power-up lock acquisition, accepts runtime divider changes over a valid/ready handshake, qualifies LOCK, retries on timeout and reacts to lock loss. Generates sys_rst_n for the PLL-clocked PSRAM/user logic. Clocked from the 27 MHz board clock, never from the PLL output.

Parameters:
RST_CYCLES, 16, cycles pll_reset held high per reset attempt (>=2)
LOCK_TIMEOUT, 65535, cycles to wait for synchronised lock before one retry is consumed
STABLE_CYCLES, 256, consecutive high-lock cycles required before release
MAX_RETRIES, 3, failed attempts before FAIL (>=1)
DRAIN_CYCLES, 4, cycles sys_rst_n is held low before pll_reset rises on reconfig
DEF_IDSEL, 6'd0, reset value of pll_idsel
DEF_FBDSEL, 6'd0, reset value of pll_fbdsel
DEF_ODSEL, 6'd0, reset value of pll_odsel

Ports:
clk  in  1  27 MHz reference clock
rst_n  in  1  asynchronous, active-low reset
cfg_valid  in  1  new divider set offered
cfg_ready  out  1  controller can accept a config
cfg_idsel  in  6  requested IDSEL
cfg_fbdsel  in  6  requested FBDSEL
cfg_odsel  in  6  requested ODSEL
pll_lock  in  1  PLL LOCK, asynchronous to clk
pll_reset  out  1  to PLL RESET
pll_idsel  out  6  to PLL IDSEL
pll_fbdsel  out  6  to PLL FBDSEL
pll_odsel  out  6  to PLL ODSEL
sys_rst_n  out  1  active-low reset for PLL-clocked domain
locked  out  1  qualified lock status
busy  out  1  sequence in progress
fail  out  1  retries exhausted
lock_loss_cnt  out  8  saturating count of lock losses while in RUN

Behaviour:
- Reset (rst_n=0, async): state=PLL_RST, pll_reset=1, sys_rst_n=0, locked=0, busy=1, fail=0, cfg_ready=0, lock_loss_cnt=0, retry=0, pll_*sel=DEF_*. All outputs registered.
- pll_lock passes a 2-flop synchroniser -> lock_s (2-cycle latency). Only lock_s is used.
- States: PLL_RST, WAIT_LOCK, STABLE, RUN, DRAIN, FAIL.
- PLL_RST: pll_reset=1 for exactly RST_CYCLES cycles, then WAIT_LOCK, timeout counter cleared.
- WAIT_LOCK: pll_reset=0. lock_s=1 -> STABLE (stable counter cleared). Timeout counter reaches LOCK_TIMEOUT -> retry+1; retry==MAX_RETRIES -> FAIL, else PLL_RST.
- STABLE: lock_s low -> WAIT_LOCK; timeout counter is NOT cleared (flapping lock consumes timeout). STABLE_CYCLES consecutive highs -> RUN, retry cleared.
- RUN: locked=1, sys_rst_n=1, busy=0, cfg_ready=1, all asserted the cycle RUN is entered. lock_s low -> lock_loss_cnt+1 (saturate 255), sys_rst_n=0, locked=0, -> PLL_RST.
- Handshake: transfer when cfg_valid&&cfg_ready. cfg_ready=1 only in RUN and FAIL. On transfer: cfg_* latched into pll_*sel, retry=0, fail=0, -> DRAIN. Dividers change only on transfer and stay stable otherwise.
- DRAIN: sys_rst_n=0, locked=0, pll_reset=0 for DRAIN_CYCLES cycles, then PLL_RST. Divider buses are updated on entry to DRAIN, i.e. before pll_reset rises.
- FAIL: pll_reset=1, sys_rst_n=0, locked=0, busy=0, fail=1. Exit only via a cfg transfer (same values allowed) or rst_n.
- Simultaneous lock loss and cfg_valid in RUN: lock loss wins, cfg_ready deasserts next cycle, no transfer.
- sys_rst_n deasserts only from RUN entry; asserts within 1 cycle of leaving RUN.
- busy = state not in {RUN, FAIL}.
- rst_n mid-sequence: immediate return to reset values. lock_loss_cnt cleared.

Decomposition:
- pll_ctrl_pkg: state enum, SEL_W=6, counter widths derived via $clog2 of LOCK_TIMEOUT/STABLE_CYCLES/RST_CYCLES.
- Sub-module sync_2ff (1-bit, async active-low reset to 0) for pll_lock, reusable elsewhere.

Test Plan:
(Bench params: RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=2, DRAIN_CYCLES=4.)
- Power-up: release rst_n, raise pll_lock 20 cycles later and hold it -> pll_reset high 4 cycles; sys_rst_n/locked rise 2+8 cycles after pll_lock; cfg_ready=1.
- Timeout/fail: pll_lock held 0 -> two 4-cycle pll_reset pulses separated by 100 cycles, then FAIL: fail=1, pll_reset=1, cfg_ready=1.
- Reconfig: in RUN send cfg_idsel=3, fbdsel=10, odsel=8 -> pll_*sel update the next cycle, sys_rst_n low 4 cycles before pll_reset rises, relock reaches RUN, retry=0.
- Lock loss: drop pll_lock 1 cycle in RUN, 3 times -> sys_rst_n low within 3 cycles each time, lock_loss_cnt=3, relock each time.
- Flapping: in STABLE toggle pll_lock every 5 cycles -> RUN never entered, retry consumed at 100 cycles from the WAIT_LOCK entry.
- Async reset mid-WAIT_LOCK with cfg_valid high -> all outputs at reset values immediately, pll_*sel=DEF_*.
